// File: rtl/accumilator.sv
// accumilator: loadable, incrementing accumulator with a registered
// overflow flag and a combinational zero flag.
//   Priority per clock edge: rst > w_en > inc > hold.
//   Default build: increment wraps modulo 2^WIDTH.
//   Define ACCUMILATOR_SAT_EN: increment saturates at all-ones instead.
//   In both builds ovf pulses for one cycle after an increment whose
//   true sum did not fit in WIDTH bits.
module accumilator #(
  parameter int unsigned         WIDTH = 32,
  parameter logic [WIDTH-1:0]    STEP  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             w_en,
  input  logic             inc,
  output logic [WIDTH-1:0] data_out,
  output logic             ovf,
  output logic             zero
);

  logic [WIDTH-1:0] r_data;
  logic             r_ovf;

  // One extra bit on the adder so the carry-out is the overflow indicator.
  logic [WIDTH:0]   w_sum;
  logic             w_carry;
  logic [WIDTH-1:0] w_inc_val;
  logic [WIDTH-1:0] w_data_nxt;
  logic             w_ovf_nxt;

  assign w_sum   = {1'b0, r_data} + {1'b0, STEP};
  assign w_carry = w_sum[WIDTH];

`ifdef ACCUMILATOR_SAT_EN
  // Saturating build: clamp at all-ones whenever the true sum overflows.
  assign w_inc_val = w_carry ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
`else
  // Wrapping build: simply drop the carry.
  assign w_inc_val = w_sum[WIDTH-1:0];
`endif

  // Next-state selection following the rst > w_en > inc > hold priority.
  always_comb begin
    w_data_nxt = r_data;
    w_ovf_nxt  = 1'b0;
    if (rst) begin
      w_data_nxt = '0;
      w_ovf_nxt  = 1'b0;
    end else if (w_en) begin
      w_data_nxt = data_in;
      w_ovf_nxt  = 1'b0;
    end else if (inc) begin
      w_data_nxt = w_inc_val;
      w_ovf_nxt  = w_carry;
    end
  end

  // Accumulator and overflow registers; reset is folded into next-state logic.
  always_ff @(posedge clk) begin
    r_data <= w_data_nxt;
    r_ovf  <= w_ovf_nxt;
  end

  assign data_out = r_data;
  assign ovf      = r_ovf;
  assign zero     = (r_data == '0);

endmodule

// File: tb/tb_accumilator.sv
// Self-checking bench for accumilator: directed scenarios plus randomized
// traffic compared against an arithmetic reference model.
module tb_accumilator;
  localparam int unsigned WIDTH = 32;
  localparam logic [WIDTH-1:0] STEP = 32'd1;
  localparam longint unsigned MAXV = (64'd1 << WIDTH) - 64'd1;

  logic             clk = 1'b0;
  logic             rst, w_en, inc;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             ovf, zero;

  int n_chk  = 0;
  int n_pass = 0;

  longint unsigned m_val;
  bit              m_ovf;

  accumilator #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .w_en(w_en), .inc(inc),
    .data_out(data_out), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Drive one edge worth of inputs, advance the model, then compare all outputs.
  task automatic step(input string tag, input logic r, input logic we,
                      input logic [WIDTH-1:0] din, input logic ic);
    longint unsigned s;
    rst = r; w_en = we; data_in = din; inc = ic;
    if (r) begin
      m_val = 0; m_ovf = 0;
    end else if (we) begin
      m_val = din; m_ovf = 0;
    end else if (ic) begin
      s = m_val + longint'(STEP);
      m_ovf = (s > MAXV);
`ifdef ACCUMILATOR_SAT_EN
      m_val = m_ovf ? MAXV : s;
`else
      m_val = s % (MAXV + 1);
`endif
    end else begin
      m_ovf = 0;
    end
    @(posedge clk); #1;
    chk({tag, ".data"}, 64'(data_out), 64'(m_val));
    chk({tag, ".ovf"},  64'(ovf),      64'(m_ovf));
    chk({tag, ".zero"}, 64'(zero),     64'(m_val == 0));
  endtask

  initial begin
    rst = 1'b1; w_en = 1'b0; inc = 1'b0; data_in = '0;
    m_val = 0; m_ovf = 0;
    @(negedge clk);

    // Reset state, and reset overriding load/increment
    step("rst", 1, 1, 32'hDEAD_BEEF, 1);
    chk("rst_zero_const", 64'(data_out), 64'h0);

    // First increment after reset, then a load
    step("inc1", 0, 0, 32'h1, 1);
    chk("inc1_const", 64'(data_out), 64'h1);
    step("load_a", 0, 1, 32'h0000_000A, 0);
    chk("load_a_const", 64'(data_out), 64'hA);

    // Load wins over increment
    step("load_inc", 0, 1, 32'h5, 1);
    chk("load_wins_const", 64'(data_out), 64'h5);

    // Wrap / saturate boundary
    step("load_max", 0, 1, 32'hFFFF_FFFF, 0);
    step("inc_max", 0, 0, 32'h0, 1);
`ifdef ACCUMILATOR_SAT_EN
    chk("sat_const", 64'(data_out), 64'hFFFF_FFFF);
`else
    chk("wrap_const", 64'(data_out), 64'h0);
    chk("wrap_zero_const", 64'(zero), 64'h1);
`endif
    chk("ovf_const", 64'(ovf), 64'h1);
    step("after_ovf", 0, 0, 32'h0, 0);
    chk("ovf_one_cycle", 64'(ovf), 64'h0);

    // Count of 10 edges with reset at edge 6
    step("to0", 1, 0, 32'h0, 0);
    for (int e = 1; e <= 10; e++) begin
      step($sformatf("cnt%0d", e), (e == 6), 0, 32'h0, 1);
      if (e == 6)  chk("cnt_e6_const", 64'(data_out), 64'h0);
      if (e == 10) chk("cnt_e10_const", 64'(data_out), 64'h4);
    end

    // Idle hold after load
    step("load_1234", 0, 1, 32'h1234, 0);
    for (int e = 0; e < 5; e++) step("idle", 0, 0, 32'h0, 0);
    chk("idle_const", 64'(data_out), 64'h1234);
    chk("idle_zero_const", 64'(zero), 64'h0);

    // Randomized traffic, biased toward values near the top of the range
    for (int k = 0; k < 400; k++) begin
      logic r, we, ic;
      logic [WIDTH-1:0] d;
      r  = ($urandom_range(0, 31) == 0);
      we = ($urandom_range(0, 3) == 0);
      ic = ($urandom_range(0, 3) != 0);
      d  = ($urandom_range(0, 1) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 4)))
                                        : 32'($urandom);
      step("rnd", r, we, d, ic);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/accumilator.md
ACCUMILATOR -- requirements
Module: accumilator

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width of data_in/data_out in bits.
REQ-002 Parameter: STEP, default 1, unsigned amount added per increment, WIDTH bits.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port: clk  input  1  rising-edge clock; all state changes on this edge.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: data_in  input  WIDTH  load value.
REQ-007 Port: w_en  input  1  write enable; load data_in.
REQ-008 Port: inc  input  1  increment enable; add STEP.
REQ-009 Port: data_out  output  WIDTH  registered accumulator value.
REQ-010 Port: ovf  output  1  registered flag; high for one cycle after an increment that overflowed.
REQ-011 Port: zero  output  1  combinational; high when data_out == 0.

Function
REQ-012 data_out SHALL update only on the rising edge of clk, with one-cycle latency from sampled inputs.
REQ-013 Priority per edge: rst > w_en > inc > hold.
REQ-014 w_en=1: data_out <= data_in; ovf <= 0; inc is ignored that cycle.
REQ-015 inc=1, w_en=0: data_out <= data_out + STEP, unsigned modulo 2^WIDTH (wrap), unless ACCUMILATOR_SAT_EN is defined.
REQ-016 ovf SHALL be 1 in the cycle after an increment whose true sum exceeded 2^WIDTH-1, else 0.
REQ-017 inc=0, w_en=0: data_out holds; ovf <= 0.
REQ-018 Wrap boundary: data_out=all-ones, STEP=1, inc=1 -> data_out=0, ovf=1, zero=1.
REQ-019 inc held high SHALL increment once per clock edge, with no gaps.
REQ-020 X/undefined behaviour SHALL NOT be produced for any defined input combination.

Reset
REQ-021 rst=1 at a rising edge: data_out <= 0, ovf <= 0, regardless of w_en/inc.
REQ-022 Reset asserted mid-count SHALL abort the count; the first non-reset edge resumes from 0.
REQ-023 Before the first reset edge, the output value is undefined; benches SHALL reset first.

Configuration
REQ-024 Macro ACCUMILATOR_SAT_EN defined: the increment saturates at 2^WIDTH-1 (data_out stays all-ones), and ovf still pulses 1 on each saturating increment.
REQ-025 Macro ACCUMILATOR_SAT_EN undefined: the increment wraps modulo 2^WIDTH per REQ-015.
REQ-026 w_en load and reset behaviour SHALL be identical in both builds.

Verification
REQ-027 rst=1 for 1 edge, then inc=1, data_in=32'h1, w_en=0 for 1 edge -> data_out=32'h00000001, ovf=0.
REQ-028 After REQ-027, inc=0, w_en=1, data_in=32'h0000000A for 1 edge -> data_out=32'h0000000A.
REQ-029 w_en=1 and inc=1 together, data_in=32'h5 -> data_out=32'h5 (load wins, no increment).
REQ-030 Load 32'hFFFFFFFF, then inc=1 for 1 edge -> wrap build: data_out=0, ovf=1, zero=1; SAT build: data_out=32'hFFFFFFFF, ovf=1.
REQ-031 inc=1 for 10 edges from 0, with rst=1 at edge 6 -> data_out=0 after edge 6, and 4 after edge 10.
REQ-032 Idle after load of 32'h1234 for 5 edges -> data_out stays 32'h1234, ovf=0, zero=0.
